// File: rtl/ifft_rescale_pkg.sv
// Shared types and constants for the post-IFFT stream rescaler.
package ifft_rescale_pkg;

   typedef enum logic {
      FRAME_START = 1'b0,
      IN_FRAME    = 1'b1
   } frame_state_t;

   localparam int unsigned CLIP_W = 16;

   // Signed shift width: two unsigned exponents summed, minus LOG_DEPTH.
   function automatic int unsigned SHIFT_W(input int unsigned scale_w);
      return scale_w + 2;
   endfunction

endpackage

// File: rtl/rescale_sat_lane.sv
// Combinational shift / round / saturate for one sample component.
module rescale_sat_lane
   import ifft_rescale_pkg::*;
#(
   parameter int unsigned DATA_W   = 18,
   parameter int unsigned OUT_W    = 18,
   parameter int unsigned SCALE_W  = 4,
   parameter int unsigned ROUND_EN = 1
) (
   input  logic signed [DATA_W-1:0]           data,
   input  logic signed [SHIFT_W(SCALE_W)-1:0] shift,
   output logic signed [OUT_W-1:0]            result_c,
   output logic                               clip_c
);

   localparam int unsigned SW = SHIFT_W(SCALE_W);
   localparam int unsigned IW = DATA_W + (1 << (SCALE_W + 1));
   localparam logic signed [IW-1:0] MAX_V = {{(IW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [IW-1:0] MIN_V = {{(IW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   logic signed [IW-1:0] ext;
   logic signed [IW-1:0] rnd;
   logic signed [IW-1:0] biased;
   logic signed [IW-1:0] shifted;
   logic        [SW-1:0] amt;

   always_comb begin
      ext      = IW'(data);
      amt      = '0;
      rnd      = '0;
      biased   = '0;
      shifted  = '0;
      clip_c   = 1'b0;
      result_c = '0;

      if (!shift[SW-1]) begin
         amt     = shift;
         shifted = ext <<< amt;
      end else begin
         amt = SW'(-shift);
         // Half-LSB bias turns the floor shift into round-half-up.
         if (ROUND_EN != 0) begin
            rnd = IW'(1) << (amt - SW'(1));
         end
         biased  = ext + rnd;
         shifted = biased >>> amt;
      end

      if (shifted > MAX_V) begin
         clip_c   = 1'b1;
         result_c = MAX_V[OUT_W-1:0];
      end else if (shifted < MIN_V) begin
         clip_c   = 1'b1;
         result_c = MIN_V[OUT_W-1:0];
      end else begin
         result_c = shifted[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/ifft_stream_rescaler.sv
// Two-stage valid/ready rescaler undoing FFT/IFFT block exponents and 1/N.
module ifft_stream_rescaler
   import ifft_rescale_pkg::*;
#(
   parameter int unsigned DATA_W    = 18,
   parameter int unsigned OUT_W     = 18,
   parameter int unsigned LOG_DEPTH = 9,
   parameter int unsigned SCALE_W   = 4,
   parameter int unsigned ROUND_EN  = 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     from_ifft_valid,
   output logic                     from_ifft_ready,
   input  logic signed [DATA_W-1:0] from_ifft_data_real,
   input  logic signed [DATA_W-1:0] from_ifft_data_imag,
   input  logic                     from_ifft_last,
   input  logic [SCALE_W-1:0]       fft_output_scaling,
   input  logic [SCALE_W-1:0]       ifft_output_scaling,
   output logic                     to_codec_valid,
   input  logic                     to_codec_ready,
   output logic signed [OUT_W-1:0]  to_codec_data_real,
   output logic signed [OUT_W-1:0]  to_codec_data_imag,
   output logic                     to_codec_last,
   output logic [CLIP_W-1:0]        clip_count,
   output logic                     clip_flag,
   input  logic                     clip_clear
);

   localparam int unsigned SW = SHIFT_W(SCALE_W);

   frame_state_t            state;
   logic signed [SW-1:0]    latched_s;
   logic signed [SW-1:0]    new_s_c;
   logic signed [SW-1:0]    active_s_c;
   logic                    en_c;
   logic                    accept_c;

   logic                    s1_valid;
   logic                    s1_last;
   logic signed [DATA_W-1:0] s1_real;
   logic signed [DATA_W-1:0] s1_imag;
   logic signed [SW-1:0]    s1_shift;

   logic signed [OUT_W-1:0] lane_real_c;
   logic signed [OUT_W-1:0] lane_imag_c;
   logic                    clip_real_c;
   logic                    clip_imag_c;
   logic                    clip_c;

   // Whole pipeline moves together; a stalled output freezes everything.
   assign en_c            = !to_codec_valid || to_codec_ready;
   assign from_ifft_ready = en_c;
   assign accept_c        = from_ifft_valid && en_c;

   assign new_s_c    = SW'(fft_output_scaling) + SW'(ifft_output_scaling) - SW'(LOG_DEPTH);
   assign active_s_c = (state == FRAME_START) ? new_s_c : latched_s;

   // Frame tracking: scaling is captured only on the first sample of a frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= FRAME_START;
         latched_s <= '0;
      end else if (accept_c) begin
         if (state == FRAME_START) begin
            latched_s <= new_s_c;
         end
         state <= from_ifft_last ? FRAME_START : IN_FRAME;
      end
   end

   // Stage 1: capture sample with the shift that applies to it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s1_real  <= '0;
         s1_imag  <= '0;
         s1_shift <= '0;
      end else if (en_c) begin
         s1_valid <= from_ifft_valid;
         if (from_ifft_valid) begin
            s1_real  <= from_ifft_data_real;
            s1_imag  <= from_ifft_data_imag;
            s1_last  <= from_ifft_last;
            s1_shift <= active_s_c;
         end
      end
   end

   rescale_sat_lane #(
      .DATA_W   (DATA_W),
      .OUT_W    (OUT_W),
      .SCALE_W  (SCALE_W),
      .ROUND_EN (ROUND_EN)
   ) u_lane_real (
      .data     (s1_real),
      .shift    (s1_shift),
      .result_c (lane_real_c),
      .clip_c   (clip_real_c)
   );

   rescale_sat_lane #(
      .DATA_W   (DATA_W),
      .OUT_W    (OUT_W),
      .SCALE_W  (SCALE_W),
      .ROUND_EN (ROUND_EN)
   ) u_lane_imag (
      .data     (s1_imag),
      .shift    (s1_shift),
      .result_c (lane_imag_c),
      .clip_c   (clip_imag_c)
   );

   // Stage 2: output register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         to_codec_valid     <= 1'b0;
         to_codec_last      <= 1'b0;
         to_codec_data_real <= '0;
         to_codec_data_imag <= '0;
      end else if (en_c) begin
         to_codec_valid <= s1_valid;
         if (s1_valid) begin
            to_codec_last      <= s1_last;
            to_codec_data_real <= lane_real_c;
            to_codec_data_imag <= lane_imag_c;
         end
      end
   end

   assign clip_c = en_c && s1_valid && (clip_real_c || clip_imag_c);

   // Clip statistics: one count per sample entering the output register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clip_count <= '0;
         clip_flag  <= 1'b0;
      end else if (clip_clear) begin
         clip_count <= '0;
         clip_flag  <= 1'b0;
      end else if (clip_c) begin
         if (clip_count != '1) begin
            clip_count <= clip_count + CLIP_W'(1);
         end
         clip_flag <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ifft_stream_rescaler.sv
// Randomised bench for ifft_stream_rescaler with a floor-division reference model.
module tb_ifft_stream_rescaler;

   localparam int DATA_W    = 18;
   localparam int OUT_W     = 18;
   localparam int LOG_DEPTH = 9;
   localparam int SCALE_W   = 4;

   typedef struct packed {
      logic signed [31:0] re;
      logic signed [31:0] im;
      logic signed [31:0] re_t;
      logic signed [31:0] im_t;
      logic               last;
   } smp_t;

   typedef struct {
      int re;
      int im;
      bit last;
      int fft;
      int ifft;
   } stim_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic from_ifft_valid, from_ifft_last, to_codec_ready, clip_clear;
   logic signed [DATA_W-1:0] from_ifft_data_real, from_ifft_data_imag;
   logic [SCALE_W-1:0] fft_output_scaling, ifft_output_scaling;

   logic from_ifft_ready, to_codec_valid, to_codec_last, clip_flag;
   logic signed [OUT_W-1:0] to_codec_data_real, to_codec_data_imag;
   logic [15:0] clip_count;

   logic ready_t, valid_t, last_t, flag_t;
   logic signed [OUT_W-1:0] real_t, imag_t;
   logic [15:0] count_t;

   smp_t  exp_q[$];
   smp_t  obs_q[$];
   stim_t src[$];
   int    m_s;
   bit    m_in_frame;
   int    m_clip;
   int    checks = 0;
   int    errors = 0;

   always #5 clk = ~clk;

   ifft_stream_rescaler #(
      .DATA_W(DATA_W), .OUT_W(OUT_W), .LOG_DEPTH(LOG_DEPTH), .SCALE_W(SCALE_W), .ROUND_EN(1)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .from_ifft_valid(from_ifft_valid), .from_ifft_ready(from_ifft_ready),
      .from_ifft_data_real(from_ifft_data_real), .from_ifft_data_imag(from_ifft_data_imag),
      .from_ifft_last(from_ifft_last),
      .fft_output_scaling(fft_output_scaling), .ifft_output_scaling(ifft_output_scaling),
      .to_codec_valid(to_codec_valid), .to_codec_ready(to_codec_ready),
      .to_codec_data_real(to_codec_data_real), .to_codec_data_imag(to_codec_data_imag),
      .to_codec_last(to_codec_last),
      .clip_count(clip_count), .clip_flag(clip_flag), .clip_clear(clip_clear)
   );

   ifft_stream_rescaler #(
      .DATA_W(DATA_W), .OUT_W(OUT_W), .LOG_DEPTH(LOG_DEPTH), .SCALE_W(SCALE_W), .ROUND_EN(0)
   ) dut_t (
      .clk(clk), .reset_n(reset_n),
      .from_ifft_valid(from_ifft_valid), .from_ifft_ready(ready_t),
      .from_ifft_data_real(from_ifft_data_real), .from_ifft_data_imag(from_ifft_data_imag),
      .from_ifft_last(from_ifft_last),
      .fft_output_scaling(fft_output_scaling), .ifft_output_scaling(ifft_output_scaling),
      .to_codec_valid(valid_t), .to_codec_ready(to_codec_ready),
      .to_codec_data_real(real_t), .to_codec_data_imag(imag_t),
      .to_codec_last(last_t),
      .clip_count(count_t), .clip_flag(flag_t), .clip_clear(clip_clear)
   );

   // Ideal value: x * 2^s, with negative s as floor((x + half) / 2^-s), then clamped.
   function automatic int rescale(input int x, input int s, input bit rnd, output bit clip);
      longint num, d, q, hi, lo;
      hi = (longint'(1) << (OUT_W - 1)) - 1;
      lo = -hi - 1;
      if (s >= 0) begin
         q = longint'(x) * (longint'(1) << s);
      end else begin
         d   = longint'(1) << (-s);
         num = longint'(x) + (rnd ? d / 2 : longint'(0));
         q   = num / d;
         if ((num % d != 0) && (num < 0)) q = q - 1;
      end
      clip = (q > hi) || (q < lo);
      if (q > hi) q = hi;
      else if (q < lo) q = lo;
      return int'(q);
   endfunction

   // Reference model on accepted inputs plus recorder of delivered outputs.
   always @(posedge clk or negedge reset_n) begin
      smp_t e, o;
      bit c1, c2, c3, c4;
      if (!reset_n) begin
         m_in_frame = 1'b0;
         m_clip     = 0;
      end else begin
         if (from_ifft_valid && from_ifft_ready) begin
            if (!m_in_frame)
               m_s = int'(fft_output_scaling) + int'(ifft_output_scaling) - LOG_DEPTH;
            e.re   = rescale(int'(from_ifft_data_real), m_s, 1'b1, c1);
            e.im   = rescale(int'(from_ifft_data_imag), m_s, 1'b1, c2);
            e.re_t = rescale(int'(from_ifft_data_real), m_s, 1'b0, c3);
            e.im_t = rescale(int'(from_ifft_data_imag), m_s, 1'b0, c4);
            e.last = from_ifft_last;
            exp_q.push_back(e);
            if (c1 || c2) m_clip++;
            m_in_frame = !from_ifft_last;
         end
         if (to_codec_valid && to_codec_ready) begin
            o.re   = int'(to_codec_data_real);
            o.im   = int'(to_codec_data_imag);
            o.re_t = int'(real_t);
            o.im_t = int'(imag_t);
            o.last = to_codec_last;
            obs_q.push_back(o);
         end
      end
   end

   task automatic drive_idle();
      from_ifft_valid     = 1'b0;
      from_ifft_last      = 1'b0;
      from_ifft_data_real = '0;
      from_ifft_data_imag = '0;
      fft_output_scaling  = '0;
      ifft_output_scaling = '0;
      to_codec_ready      = 1'b1;
      clip_clear          = 1'b0;
   endtask

   task automatic drive_src(input int idx);
      from_ifft_valid     = 1'b1;
      from_ifft_data_real = DATA_W'(src[idx].re);
      from_ifft_data_imag = DATA_W'(src[idx].im);
      from_ifft_last      = src[idx].last;
      fft_output_scaling  = SCALE_W'(src[idx].fft);
      ifft_output_scaling = SCALE_W'(src[idx].ifft);
   endtask

   // One sample into an empty, free-flowing pipe; returns one cycle after acceptance.
   task automatic send_one(input int re, input int im, input bit last, input int f, input int fi);
      src.delete();
      src.push_back('{re, im, last, f, fi});
      @(negedge clk);
      drive_src(0);
      @(negedge clk);
      from_ifft_valid = 1'b0;
      src.delete();
   endtask

   task automatic clear_clip();
      @(negedge clk);
      clip_clear = 1'b1;
      @(negedge clk);
      clip_clear = 1'b0;
      m_clip     = 0;
   endtask

   task automatic flush_queues();
      @(negedge clk);
      @(negedge clk);
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic run_stream(input bit rand_ready);
      int idx = 0;
      int cyc = 0;
      int total = src.size();
      while (obs_q.size() < total && cyc < 2000) begin
         @(negedge clk);
         to_codec_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (idx < total) drive_src(idx);
         else from_ifft_valid = 1'b0;
         #1;
         if (from_ifft_valid && from_ifft_ready) idx++;
         cyc++;
      end
      @(negedge clk);
      from_ifft_valid = 1'b0;
      to_codec_ready  = 1'b1;
      src.delete();
   endtask

   task automatic test_reset();
      #1;
      checks++; if (to_codec_valid !== 1'b0 || valid_t !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b/%0b want 0", to_codec_valid, valid_t); end
      checks++; if (to_codec_last !== 1'b0) begin errors++; $display("FAIL reset_last got %0b want 0", to_codec_last); end
      checks++; if (to_codec_data_real !== '0 || to_codec_data_imag !== '0) begin errors++; $display("FAIL reset_data got %0d/%0d want 0", to_codec_data_real, to_codec_data_imag); end
      checks++; if (clip_count !== 16'd0 || clip_flag !== 1'b0) begin errors++; $display("FAIL reset_clip got %0d/%0b want 0/0", clip_count, clip_flag); end
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      checks++; if (from_ifft_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", from_ifft_ready); end
   endtask

   task automatic test_latency();
      send_one(1000, -1000, 1'b1, 4, 5);
      checks++; if (to_codec_valid !== 1'b0) begin errors++; $display("FAIL lat_early_valid got %0b want 0", to_codec_valid); end
      @(negedge clk);
      checks++; if (to_codec_valid !== 1'b1) begin errors++; $display("FAIL lat_valid got %0b want 1", to_codec_valid); end
      checks++; if (to_codec_data_real !== 18'sd1000 || to_codec_data_imag !== -18'sd1000) begin errors++; $display("FAIL lat_data got %0d/%0d want 1000/-1000", to_codec_data_real, to_codec_data_imag); end
      checks++; if (to_codec_last !== 1'b1 || clip_count !== 16'd0) begin errors++; $display("FAIL lat_last_clip got %0b/%0d want 1/0", to_codec_last, clip_count); end
      flush_queues();
   endtask

   task automatic test_round();
      send_one(-1000, 23, 1'b1, 2, 3);
      @(negedge clk);
      checks++; if (to_codec_data_real !== -18'sd62 || to_codec_data_imag !== 18'sd1) begin errors++; $display("FAIL round_half_up got %0d/%0d want -62/1", to_codec_data_real, to_codec_data_imag); end
      checks++; if (real_t !== -18'sd63 || imag_t !== 18'sd1) begin errors++; $display("FAIL round_trunc got %0d/%0d want -63/1", real_t, imag_t); end
      flush_queues();
   endtask

   task automatic test_clip();
      send_one(3000, -3000, 1'b1, 7, 8);
      @(negedge clk);
      checks++; if (to_codec_data_real !== 18'sd131071 || to_codec_data_imag !== -18'sd131072) begin errors++; $display("FAIL clip_data got %0d/%0d want 131071/-131072", to_codec_data_real, to_codec_data_imag); end
      checks++; if (clip_count !== 16'd1 || clip_flag !== 1'b1) begin errors++; $display("FAIL clip_count got %0d/%0b want 1/1", clip_count, clip_flag); end
      clear_clip();
      checks++; if (clip_count !== 16'd0 || clip_flag !== 1'b0) begin errors++; $display("FAIL clip_clear got %0d/%0b want 0/0", clip_count, clip_flag); end
      // Clear lands on the same edge the clipped sample enters the output register.
      send_one(3000, 3000, 1'b1, 7, 8);
      clip_clear = 1'b1;
      @(negedge clk);
      clip_clear = 1'b0;
      checks++; if (clip_count !== 16'd0 || clip_flag !== 1'b0 || to_codec_data_real !== 18'sd131071) begin errors++; $display("FAIL clip_clear_priority got %0d/%0b/%0d want 0/0/131071", clip_count, clip_flag, to_codec_data_real); end
      flush_queues();
      m_clip = 0;
   endtask

   task automatic test_frame();
      for (int i = 0; i < 4; i++)
         src.push_back('{100 * (i + 1), -100 * (i + 1), i == 3, (i < 2) ? 4 : 0, 5});
      src.push_back('{-1000, 23, 1'b1, 0, 5});
      run_stream(1'b0);
      checks++; if (obs_q.size() !== 5 || exp_q.size() !== 5) begin errors++; $display("FAIL frame_count got %0d/%0d want 5", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i].re !== 100 * (i + 1) || obs_q[i].im !== -100 * (i + 1) || obs_q[i].last !== (i == 3))
            begin errors++; $display("FAIL frame_s0[%0d] got %0d/%0d/%0b want %0d/%0d", i, obs_q[i].re, obs_q[i].im, obs_q[i].last, 100 * (i + 1), -100 * (i + 1)); end
      end
      if (obs_q.size() > 4) begin
         checks++; if (obs_q[4].re !== -62 || obs_q[4].re_t !== -63 || obs_q[4].im !== 1) begin errors++; $display("FAIL frame_next got %0d/%0d/%0d want -62/-63/1", obs_q[4].re, obs_q[4].re_t, obs_q[4].im); end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_back_to_back();
      int idx = 0;
      int cyc = 0;
      bit held = 1'b0;
      logic [2*OUT_W:0] snap;
      for (int i = 0; i < 8; i++)
         src.push_back('{int'($urandom_range(0, 262143)) - 131072, int'($urandom_range(0, 262143)) - 131072, i == 7, 4, 4});
      while (obs_q.size() < 8 && cyc < 200) begin
         @(negedge clk);
         to_codec_ready = !(cyc >= 3 && cyc < 6);
         if (idx < 8) drive_src(idx);
         else from_ifft_valid = 1'b0;
         #1;
         if (held) begin
            checks++;
            if ({to_codec_valid, to_codec_last, to_codec_data_real, to_codec_data_imag} !== {1'b1, snap})
               begin errors++; $display("FAIL stall_hold cyc %0d got %0b/%0b/%0d/%0d", cyc, to_codec_valid, to_codec_last, to_codec_data_real, to_codec_data_imag); end
         end
         held = to_codec_valid && !to_codec_ready;
         if (held) begin
            checks++; if (from_ifft_ready !== 1'b0) begin errors++; $display("FAIL stall_ready cyc %0d got %0b want 0", cyc, from_ifft_ready); end
            snap = {to_codec_last, to_codec_data_real, to_codec_data_imag};
         end
         if (from_ifft_valid && from_ifft_ready) idx++;
         cyc++;
      end
      @(negedge clk);
      from_ifft_valid = 1'b0;
      to_codec_ready  = 1'b1;
      src.delete();
      checks++; if (obs_q.size() !== 8 || exp_q.size() !== 8) begin errors++; $display("FAIL b2b_count got %0d/%0d want 8", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b[%0d] got %0d/%0d/%0d/%0d/%0b want %0d/%0d/%0d/%0d/%0b", i,
            obs_q[i].re, obs_q[i].im, obs_q[i].re_t, obs_q[i].im_t, obs_q[i].last, exp_q[i].re, exp_q[i].im, exp_q[i].re_t, exp_q[i].im_t, exp_q[i].last); end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_random();
      int n = 0;
      clear_clip();
      for (int f = 0; f < 6; f++) begin
         int len = int'($urandom_range(1, 8));
         for (int i = 0; i < len; i++)
            src.push_back('{int'($urandom_range(0, 262143)) - 131072, int'($urandom_range(0, 262143)) - 131072,
                            i == len - 1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15))});
         n += len;
      end
      run_stream(1'b1);
      checks++; if (obs_q.size() !== n || exp_q.size() !== n) begin errors++; $display("FAIL rand_count got %0d/%0d want %0d", obs_q.size(), exp_q.size(), n); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand[%0d] got %0d/%0d/%0d/%0d/%0b want %0d/%0d/%0d/%0d/%0b", i,
            obs_q[i].re, obs_q[i].im, obs_q[i].re_t, obs_q[i].im_t, obs_q[i].last, exp_q[i].re, exp_q[i].im, exp_q[i].re_t, exp_q[i].im_t, exp_q[i].last); end
      end
      checks++; if (int'(clip_count) !== m_clip || clip_flag !== (m_clip != 0)) begin errors++; $display("FAIL rand_clip got %0d/%0b want %0d/%0b", clip_count, clip_flag, m_clip, m_clip != 0); end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_reset_mid_frame();
      clear_clip();
      src.push_back('{3000, -3000, 1'b0, 7, 8});
      src.push_back('{-3000, 3000, 1'b0, 7, 8});
      run_stream(1'b0);
      checks++; if (clip_count !== 16'd2) begin errors++; $display("FAIL mid_clip_before got %0d want 2", clip_count); end
      @(negedge clk);
      from_ifft_valid     = 1'b1;
      from_ifft_data_real = 18'sd5;
      from_ifft_last      = 1'b0;
      @(negedge clk);
      from_ifft_valid = 1'b0;
      @(negedge clk);
      checks++; if (to_codec_valid !== 1'b1) begin errors++; $display("FAIL mid_valid_before got %0b want 1", to_codec_valid); end
      reset_n = 1'b0;
      #1;
      checks++; if (to_codec_valid !== 1'b0 || clip_count !== 16'd0 || clip_flag !== 1'b0) begin errors++; $display("FAIL mid_reset got %0b/%0d/%0b want 0/0/0", to_codec_valid, clip_count, clip_flag); end
      @(negedge clk);
      reset_n = 1'b1;
      exp_q.delete();
      obs_q.delete();
      src.push_back('{-1000, 23, 1'b1, 2, 3});
      run_stream(1'b0);
      checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL mid_count got %0d want 1", obs_q.size()); end
      if (obs_q.size() > 0) begin
         checks++; if (obs_q[0].re !== -62 || obs_q[0].re_t !== -63 || obs_q[0].im !== 1 || obs_q[0].last !== 1'b1) begin errors++; $display("FAIL mid_relatch got %0d/%0d/%0d/%0b want -62/-63/1/1", obs_q[0].re, obs_q[0].re_t, obs_q[0].im, obs_q[0].last); end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   initial begin
      drive_idle();
      test_reset();
      test_latency();
      test_round();
      test_clip();
      test_frame();
      test_back_to_back();
      test_random();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
